// File: rtl/truth_table_sweeper_pkg.sv
// Shared encodings and widths for the truth-table sweeper.
// Imported by the top level and the dwell counter.
package truth_table_sweeper_pkg;

  localparam int NUM_VECS = 16;
  localparam int IDX_W    = 4;
  localparam int CNT_W    = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sweep_dwell_cnt.sv
// Dwell counter: counts clocks a vector has been held.
// last flags the final clock of the dwell window.
module sweep_dwell_cnt
  import truth_table_sweeper_pkg::*;
#(
  parameter int DWELL = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  logic [CNT_W-1:0] cnt;

  assign last = (cnt == CNT_W'(DWELL - 1));

  // clear has priority so the count restarts per vector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps 16 wxyz vectors and captures F1/F2 truth tables.
// Optional checker against EXP_F1/EXP_F2 under SWEEP_CHECK_EN.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int          DWELL  = 5,
  parameter logic [15:0] EXP_F1 = 16'h0000,
  parameter logic [15:0] EXP_F2 = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             w,
  output logic             x,
  output logic             y,
  output logic             z,
  input  logic             F1,
  input  logic             F2,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] vec_idx,
  output logic [15:0]      f1_tab,
  output logic [15:0]      f2_tab
`ifdef SWEEP_CHECK_EN
  ,
  output logic             mismatch,
  output logic [IDX_W-1:0] mis_idx
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECS - 1);

  state_t state, state_nx;
  logic   last;
  logic   go;
  logic   sample;

  assign go     = (state == S_IDLE) && start && !abort;
  assign sample = (state == S_RUN) && !abort && last;

  assign w = vec_idx[3];
  assign x = vec_idx[2];
  assign y = vec_idx[1];
  assign z = vec_idx[0];

  sweep_dwell_cnt #(
    .DWELL (DWELL)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  ((state != S_RUN) || last),
    .en   (state == S_RUN),
    .last (last)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // next-state logic; abort beats start and sampling
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (go) state_nx = S_RUN;
      S_RUN: begin
        if (abort)
          state_nx = S_IDLE;
        else if (last && vec_idx == LAST_IDX)
          state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // index, tables and registered status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_idx <= '0;
      f1_tab  <= '0;
      f2_tab  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      busy <= (state_nx == S_RUN);
      done <= (state == S_RUN) && (state_nx == S_DONE);
      unique case (state)
        S_IDLE: begin
          if (go) begin
            vec_idx <= '0;
            f1_tab  <= '0;
            f2_tab  <= '0;
          end
        end
        S_RUN: begin
          if (abort) begin
            vec_idx <= '0;
          end else if (last) begin
            f1_tab[vec_idx] <= F1;
            f2_tab[vec_idx] <= F2;
            if (vec_idx != LAST_IDX)
              vec_idx <= vec_idx + 1'b1;
          end
        end
        S_DONE:  vec_idx <= '0;
        default: vec_idx <= '0;
      endcase
    end
  end

`ifdef SWEEP_CHECK_EN
  logic miss;

  assign miss = (F1 != EXP_F1[vec_idx]) ||
                (F2 != EXP_F2[vec_idx]);

  // sticky first-miss capture, cleared when a sweep starts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch <= 1'b0;
      mis_idx  <= '0;
    end else if (go) begin
      mismatch <= 1'b0;
      mis_idx  <= '0;
    end else if (sample && miss && !mismatch) begin
      mismatch <= 1'b1;
      mis_idx  <= vec_idx;
    end
  end
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper (DWELL=5 and DWELL=1).
// Model: F1 = w ^ x, F2 = y & z; checker tests need SWEEP_CHECK_EN.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force_f1 = 1'b0;

  logic start5 = 1'b0, abort5 = 1'b0;
  logic w5, x5, y5, z5, f1_5, f2_5, busy5, done5;
  logic [3:0]  vec5;
  logic [15:0] t1_5, t2_5;

  logic start1 = 1'b0, abort1 = 1'b0;
  logic w1, x1, y1, z1, f1_1, f2_1, busy1, done1;
  logic [3:0]  vec1;
  logic [15:0] t1_1, t2_1;

`ifdef SWEEP_CHECK_EN
  logic       mis5, mis1;
  logic [3:0] misi5, misi1;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int n_done   = 0;

  always #5 clk = ~clk;

  assign f1_5 = force_f1 ? 1'b0 : (w5 ^ x5);
  assign f2_5 = y5 & z5;
  assign f1_1 = w1 ^ x1;
  assign f2_1 = y1 & z1;

  truth_table_sweeper #(
    .DWELL(5), .EXP_F1(16'h0FF0), .EXP_F2(16'h8888)
  ) u5 (
    .clk(clk), .rst(rst), .start(start5), .abort(abort5),
    .w(w5), .x(x5), .y(y5), .z(z5), .F1(f1_5), .F2(f2_5),
    .busy(busy5), .done(done5), .vec_idx(vec5),
    .f1_tab(t1_5), .f2_tab(t2_5)
`ifdef SWEEP_CHECK_EN
    , .mismatch(mis5), .mis_idx(misi5)
`endif
  );

  truth_table_sweeper #(
    .DWELL(1), .EXP_F1(16'h0FF0), .EXP_F2(16'h8888)
  ) u1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1),
    .w(w1), .x(x1), .y(y1), .z(z1), .F1(f1_1), .F2(f2_1),
    .busy(busy1), .done(done1), .vec_idx(vec1),
    .f1_tab(t1_1), .f2_tab(t2_1)
`ifdef SWEEP_CHECK_EN
    , .mismatch(mis1), .mis_idx(misi1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // 1: reset and idle
    #12;
    chk("rst5_outs", {busy5, done5, vec5, t1_5, t2_5}, 0);
    chk("rst1_outs", {busy1, done1, vec1, t1_1, t2_1}, 0);
    rst = 1'b0;
    repeat (10) tick();
    chk("idle5_outs", {busy5, done5, w5, x5, y5, z5, t1_5, t2_5}, 0);
    chk("idle1_outs", {busy1, done1, w1, x1, y1, z1, t1_1, t2_1}, 0);

    // 2: full DWELL=5 sweep, with a stray start mid-run
    start5 = 1'b1;
    tick();
    start5 = 1'b0;
    chk("s2_busy_k", busy5, 1);
    chk("s2_wxyz_k", {w5, x5, y5, z5}, 0);
    for (int t = 1; t <= 80; t++) begin
      start5 = (t == 17);
      tick();
      start5 = 1'b0;
      if (t < 80) begin
        chk("s2_wxyz", {w5, x5, y5, z5}, t / 5);
        chk("s2_busy", busy5, 1);
        chk("s2_done", done5, 0);
      end
    end
    chk("s2_done_k80", done5, 1);
    chk("s2_busy_k80", busy5, 0);
    chk("s2_wxyz_k80", {w5, x5, y5, z5}, 4'hF);
    chk("s2_f1tab", t1_5, 16'h0FF0);
    chk("s2_f2tab", t2_5, 16'h8888);
`ifdef SWEEP_CHECK_EN
    chk("s5_mis_clean", mis5, 0);
`endif
    tick();
    chk("s2_done_drop", done5, 0);
    chk("s2_wxyz_idle", {w5, x5, y5, z5}, 0);

    // 3: DWELL=1 with start held 40 clocks
    start1 = 1'b1;
    tick();
    n_done = 0;
    for (int t = 1; t <= 40; t++) begin
      start1 = (t <= 39);
      tick();
      if (done1) n_done++;
      chk("s3_done", done1, (t == 16 || t == 34));
      chk("s3_busy", busy1,
          !(t == 16 || t == 17 || t == 34 || t == 35));
      if (t == 16 || t == 34) begin
        chk("s3_f1tab", t1_1, 16'h0FF0);
        chk("s3_f2tab", t2_1, 16'h8888);
      end
    end
    chk("s3_ndone", n_done, 2);
    start1 = 1'b0;
    abort1 = 1'b1;
    tick();
    abort1 = 1'b0;
    chk("s3_abort_busy", busy1, 0);

    // 4: abort during vector 6
    start5 = 1'b1;
    tick();
    start5 = 1'b0;
    repeat (32) tick();
    chk("s4_vec6", vec5, 6);
    abort5 = 1'b1;
    tick();
    abort5 = 1'b0;
    chk("s4_busy", busy5, 0);
    chk("s4_wxyz", {w5, x5, y5, z5}, 0);
    chk("s4_f1tab", t1_5, 16'h0030);
    chk("s4_f2tab", t2_5, 16'h0008);
    n_done = 0;
    for (int t = 0; t < 90; t++) begin
      tick();
      if (done5) n_done++;
    end
    chk("s4_no_done", n_done, 0);
    start5 = 1'b1;
    abort5 = 1'b1;
    tick();
    start5 = 1'b0;
    abort5 = 1'b0;
    chk("s4_abort_wins", busy5, 0);
    chk("s4_tab_kept", t1_5, 16'h0030);

`ifdef SWEEP_CHECK_EN
    // 5: checker catches a stuck-low F1
    force_f1 = 1'b1;
    start5 = 1'b1;
    tick();
    start5 = 1'b0;
    repeat (80) tick();
    force_f1 = 1'b0;
    chk("s5_done", done5, 1);
    chk("s5_mis", mis5, 1);
    chk("s5_mis_idx", misi5, 4);
    tick();
`endif

    // 6: async reset at vector 9, then a clean sweep
    start5 = 1'b1;
    tick();
    start5 = 1'b0;
    repeat (45) tick();
    chk("s6_vec9", vec5, 9);
    #2 rst = 1'b1;
    #1;
    chk("s6_rst_outs", {busy5, done5, vec5, t1_5, t2_5}, 0);
    tick();
    rst = 1'b0;
    tick();
    start5 = 1'b1;
    tick();
    start5 = 1'b0;
    repeat (79) tick();
    chk("s6_pre_done", done5, 0);
    tick();
    chk("s6_done", done5, 1);
    chk("s6_f1tab", t1_5, 16'h0FF0);
    chk("s6_f2tab", t2_5, 16'h8888);
`ifdef SWEEP_CHECK_EN
    chk("s6_mis", mis5, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
